// File: rtl/m_mem_unit.sv
// M-stage data-memory access unit: address checking, req/ack bus sequencing,
// store lane steering and load extension for the P7 pipeline.
module m_mem_unit #(
    parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
    parameter logic [4:0]  EXC_ADEL = 5'd4,
    parameter logic [4:0]  EXC_ADES = 5'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Req,
    input  logic [3:0]  M_memop,
    input  logic [31:0] M_addr,
    input  logic [31:0] M_wdata,
    output logic [31:0] M_DMRD,
    output logic        M_stall,
    output logic [4:0]  M_exc,
    output logic        m_data_req,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic        m_data_ack,
    input  logic [31:0] m_data_rdata
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic        drop_reg;
    logic [3:0]  op_reg;
    logic [1:0]  lane_reg;

    logic        is_load, is_store, is_word, is_half, misaligned;
    logic        in_dm, in_timer, in_intgen, bad_addr, launch;
    logic [4:0]  exc_code;
    logic [3:0]  st_en;
    logic [31:0] st_data;
    logic [7:0]  rd_byte [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // ---------------- operation decode and address checks ----------------
    assign is_load  = (M_memop >= OP_LW) && (M_memop <= OP_LBU);
    assign is_store = (M_memop >= OP_SW) && (M_memop <= OP_SB);
    assign is_word  = (M_memop == OP_LW) || (M_memop == OP_SW);
    assign is_half  = (M_memop == OP_LH) || (M_memop == OP_LHU) || (M_memop == OP_SH);

    assign misaligned = is_word ? (M_addr[1:0] != 2'b00) : (is_half & M_addr[0]);

    assign in_dm     = (M_addr <= DM_TOP);
    assign in_timer  = ((M_addr >= 32'h0000_7F00) && (M_addr <= 32'h0000_7F0B)) ||
                       ((M_addr >= 32'h0000_7F10) && (M_addr <= 32'h0000_7F1B));
    assign in_intgen = (M_addr >= 32'h0000_7F20) && (M_addr <= 32'h0000_7F23);

    // Timer registers are word-only, and their count registers are read-only.
    assign bad_addr = misaligned
                    || !(in_dm || in_timer || in_intgen)
                    || (in_timer && !is_word)
                    || (is_store && ((M_addr == 32'h0000_7F08) || (M_addr == 32'h0000_7F18)));

    assign exc_code = !bad_addr ? 5'd0 : (is_store ? EXC_ADES : EXC_ADEL);

    assign M_exc   = (!rst && state_reg == IDLE && (is_load || is_store)) ? exc_code : 5'd0;
    assign launch  = (state_reg == IDLE) && (is_load || is_store) && (exc_code == 5'd0) && !Req;
    assign M_stall = !rst && (launch || state_reg == BUSY);

    // ---------------- store lane steering / read lane split ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = m_data_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        st_en   = 4'b0000;
        st_data = 32'd0;
        case (M_memop)
            OP_SW: begin
                st_en   = 4'b1111;
                st_data = M_wdata;
            end
            OP_SH: begin
                st_en   = M_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{M_wdata[15:0]}};
            end
            OP_SB: begin
                st_en   = 4'b0001 << M_addr[1:0];
                st_data = {4{M_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = rd_byte[lane_reg];
        ld_half = lane_reg[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
        case (op_reg)
            OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_ext = {16'd0, ld_half};
            OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_ext = {24'd0, ld_byte};
            default: ld_ext = m_data_rdata;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = BUSY;
            BUSY:    if (m_data_ack) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- bus and result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_DMRD        <= 32'd0;
            m_data_req    <= 1'b0;
            m_data_addr   <= 32'd0;
            m_data_wdata  <= 32'd0;
            m_data_byteen <= 4'd0;
            drop_reg      <= 1'b0;
            op_reg        <= 4'd0;
            lane_reg      <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    drop_reg <= 1'b0;
                    if (launch) begin
                        m_data_req    <= 1'b1;
                        m_data_addr   <= {M_addr[31:2], 2'b00};
                        m_data_wdata  <= st_data;
                        m_data_byteen <= st_en;
                        op_reg        <= M_memop;
                        lane_reg      <= M_addr[1:0];
                    end
                end
                BUSY: begin
                    // A cancelled access still has to finish on the bus.
                    if (Req) drop_reg <= 1'b1;
                    if (m_data_ack) begin
                        m_data_req <= 1'b0;
                        if ((op_reg >= OP_LW) && (op_reg <= OP_LBU) && !drop_reg && !Req)
                            M_DMRD <= ld_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_unit.sv
// Scoreboard bench for m_mem_unit: drives loads/stores with variable ack
// latency, exception cases, cancellation and asynchronous reset.
module tb_m_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Req;
    logic [3:0]  M_memop;
    logic [31:0] M_addr;
    logic [31:0] M_wdata;
    logic [31:0] M_DMRD;
    logic        M_stall;
    logic [4:0]  M_exc;
    logic        m_data_req;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic        m_data_ack;
    logic [31:0] m_data_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] dmrd_model;

    always #5 clk = ~clk;

    m_mem_unit dut (
        .clk(clk), .rst(rst), .Req(Req),
        .M_memop(M_memop), .M_addr(M_addr), .M_wdata(M_wdata),
        .M_DMRD(M_DMRD), .M_stall(M_stall), .M_exc(M_exc),
        .m_data_req(m_data_req), .m_data_addr(m_data_addr),
        .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
        .m_data_ack(m_data_ack), .m_data_rdata(m_data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * a[1:0]);
        case (op)
            4'd2:    return {{16{s[15]}}, s[15:0]};
            4'd3:    return {16'h0000, s[15:0]};
            4'd4:    return {{24{s[7]}}, s[7:0]};
            4'd5:    return {24'h000000, s[7:0]};
            default: return w;
        endcase
    endfunction

    // Called just after a rising edge; returns in the DONE cycle.
    task automatic run_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int delay, input int req_cyc);
        logic        is_load;
        logic [3:0]  exp_en;
        logic [31:0] exp_wd;
        int          stalls, reqs;
        bit          done;
        is_load = (op >= 4'd1) && (op <= 4'd5);
        exp_en  = 4'b0000;
        exp_wd  = 32'd0;
        if (op == 4'd6) begin exp_en = 4'b1111; exp_wd = wdata; end
        if (op == 4'd7) begin exp_en = addr[1] ? 4'b1100 : 4'b0011; exp_wd = {2{wdata[15:0]}}; end
        if (op == 4'd8) begin exp_en = 4'b0001 << addr[1:0]; exp_wd = {4{wdata[7:0]}}; end
        if (is_load && req_cyc < 0) dmrd_model = model_load(op, addr, rdata);
        exp_q.push_back(dmrd_model);

        M_memop = op; M_addr = addr; M_wdata = wdata; m_data_rdata = rdata; Req = 1'b0;
        #1;
        check({tag, ".launch_stall"}, {31'd0, M_stall}, 32'd1);
        check({tag, ".launch_exc"}, {27'd0, M_exc}, 32'd0);
        stalls = M_stall ? 1 : 0;
        reqs   = m_data_req ? 1 : 0;
        done   = 1'b0;
        for (int cyc = 1; cyc < 64 && !done; cyc++) begin
            @(posedge clk); #1;
            m_data_ack = (cyc == 1 + delay);
            Req        = (cyc == req_cyc);
            #1;
            if (cyc == 1) begin
                check({tag, ".bus_addr"}, m_data_addr, {addr[31:2], 2'b00});
                check({tag, ".bus_byteen"}, {28'd0, m_data_byteen}, {28'd0, exp_en});
                check({tag, ".bus_wdata"}, m_data_wdata, exp_wd);
            end
            if (!M_stall) begin
                done    = 1'b1;
                M_memop = 4'd0;
                Req     = 1'b0;
                check({tag, ".done_req"}, {31'd0, m_data_req}, 32'd0);
                if (exp_q.size() == 0) check({tag, ".sb_empty"}, 32'd0, 32'd1);
                else check({tag, ".dmrd"}, M_DMRD, exp_q.pop_front());
            end else begin
                stalls++;
                if (m_data_req) reqs++;
            end
        end
        check({tag, ".timeout"}, {31'd0, done}, 32'd1);
        check({tag, ".stall_cycles"}, stalls, 2 + delay);
        check({tag, ".req_cycles"}, reqs, 1 + delay);
        $display("TXN %s op=%0d addr=%h dmrd=%h stalls=%0d", tag, op, addr, M_DMRD, stalls);
    endtask

    task automatic run_exc(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [4:0] exp_exc);
        M_memop = op; M_addr = addr; M_wdata = 32'hFFFF_FFFF; Req = 1'b0;
        #1;
        check({tag, ".exc"}, {27'd0, M_exc}, {27'd0, exp_exc});
        check({tag, ".stall"}, {31'd0, M_stall}, 32'd0);
        @(posedge clk); #1;
        check({tag, ".no_req"}, {31'd0, m_data_req}, 32'd0);
        M_memop = 4'd0;
        $display("TXN %s op=%0d addr=%h exc=%0d", tag, op, addr, M_exc);
    endtask

    initial begin
        rst = 1'b1; Req = 1'b0; m_data_ack = 1'b0; m_data_rdata = 32'd0;
        M_memop = 4'd1; M_addr = 32'h2; M_wdata = 32'd0;
        dmrd_model = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.exc_gated", {27'd0, M_exc}, 32'd0);
        check("reset.stall", {31'd0, M_stall}, 32'd0);
        check("reset.dmrd", M_DMRD, 32'd0);
        check("reset.req", {31'd0, m_data_req}, 32'd0);
        M_memop = 4'd0;
        rst = 1'b0;
        @(posedge clk); #1;

        run_access("lw_10",   4'd1, 32'h10, 32'd0, 32'hDEADBEEF, 0, -1);
        @(posedge clk); #1;
        run_access("lb_13",   4'd4, 32'h13, 32'd0, 32'h80FF7F01, 0, -1);
        @(posedge clk); #1;
        run_access("lbu_13",  4'd5, 32'h13, 32'd0, 32'h80FF7F01, 1, -1);
        @(posedge clk); #1;
        run_access("lh_12",   4'd2, 32'h12, 32'd0, 32'h80FF7F01, 0, -1);
        @(posedge clk); #1;
        run_access("lhu_12",  4'd3, 32'h12, 32'd0, 32'h80FF7F01, 2, -1);
        @(posedge clk); #1;
        run_access("sb_21",   4'd8, 32'h21, 32'h1ACE00AB, 32'h0, 3, -1);
        @(posedge clk); #1;
        run_access("sh_22",   4'd7, 32'h22, 32'h12345678, 32'h0, 1, -1);
        @(posedge clk); #1;
        run_access("sw_7f04", 4'd6, 32'h7F04, 32'hCAFEF00D, 32'h0, 0, -1);
        @(posedge clk); #1;
        run_access("lw_7f20", 4'd1, 32'h7F20, 32'd0, 32'h00000055, 0, -1);
        @(posedge clk); #1;

        run_exc("lw_0002", 4'd1, 32'h0002, 5'd4);
        run_exc("sh_0001", 4'd7, 32'h0001, 5'd5);
        run_exc("lb_7f00", 4'd4, 32'h7F00, 5'd4);
        run_exc("sw_7f08", 4'd6, 32'h7F08, 5'd5);
        run_exc("sw_3000", 4'd6, 32'h3000, 5'd5);

        run_access("lw_req_drop", 4'd1, 32'h40, 32'd0, 32'h11111111, 2, 1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a bus access.
        M_memop = 4'd1; M_addr = 32'h44; m_data_rdata = 32'h22222222;
        @(posedge clk); #1;
        check("rst_busy.req_before", {31'd0, m_data_req}, 32'd1);
        rst = 1'b1;
        #1;
        dmrd_model = 32'd0;
        check("rst_busy.stall", {31'd0, M_stall}, 32'd0);
        check("rst_busy.exc", {27'd0, M_exc}, 32'd0);
        check("rst_busy.req", {31'd0, m_data_req}, 32'd0);
        check("rst_busy.addr", m_data_addr, 32'd0);
        check("rst_busy.byteen", {28'd0, m_data_byteen}, 32'd0);
        check("rst_busy.wdata", m_data_wdata, 32'd0);
        check("rst_busy.dmrd", M_DMRD, dmrd_model);
        M_memop = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_data_ack = 1'b1;
        @(posedge clk); #1;
        m_data_ack = 1'b0;
        check("stray_ack.stall", {31'd0, M_stall}, 32'd0);
        check("stray_ack.req", {31'd0, m_data_req}, 32'd0);
        check("stray_ack.dmrd", M_DMRD, dmrd_model);
        $display("TXN rst_mid_busy dmrd=%h req=%0d", M_DMRD, m_data_req);
        @(posedge clk); #1;

        run_access("lw_2ffc", 4'd1, 32'h2FFC, 32'd0, 32'h0BADF00D, 1, -1);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_mem_unit.md
# m_mem_unit

M-stage data-memory access unit of the P7 pipeline. It takes the decoded memory operation, the effective address from the E/M register and the forwarded store data. It drives a req/ack handshake to the system bridge (data memory, timers, interrupt generator) and stalls the pipeline while an access is outstanding. It produces the extended load result `M_DMRD` and the address-exception code consumed by CP0 and the M/W register.

## Interface
Parameters:
- `DM_TOP`, 32'h0000_2FFF, last valid data-memory byte address (DM base 0).
- `EXC_ADEL`, 5'd4, ExcCode for a load address error.
- `EXC_ADES`, 5'd5, ExcCode for a store address error.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `Req`  in  1  CP0 exception/interrupt request; the M-stage instruction is cancelled.
- `M_memop`  in  4  operation: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; other codes are treated as none.
- `M_addr`  in  32  effective byte address.
- `M_wdata`  in  32  forwarded rt value.
- `M_DMRD`  out  32  extended load result, registered.
- `M_stall`  out  1  holds F/D/E/M, combinational.
- `M_exc`  out  5  0 or AdEL/AdES, combinational.
- `m_data_req`  out  1  bus request, registered.
- `m_data_addr`  out  32  word address {addr[31:2],2'b00}, registered.
- `m_data_wdata`  out  32  lane-replicated store data, registered.
- `m_data_byteen`  out  4  byte enables; 0000 for a load, registered.
- `m_data_ack`  in  1  bridge completion, single cycle.
- `m_data_rdata`  in  32  read word, valid with ack.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- `M_exc` is evaluated combinationally in IDLE for any valid op. It is AdEL for a load and AdES for a store when any of the following holds:
  - lw address with addr[1:0]≠0.
  - lh/lhu/sh address with addr[0]≠0.
  - Address outside [0,DM_TOP], [7F00,7F0B], [7F10,7F1B] and [7F20,7F23].
  - Half or byte access to the timer range.
  - Store to 7F08 or 7F18 (timer count registers).
- An access launches in IDLE when op≠none, `M_exc`=0 and `Req`=0. On launch:
  - `M_stall`=1.
  - Bus registers load.
  - FSM goes to BUSY.
- When `M_exc`≠0, `Req`=1 or op=none, there is no bus activity and `M_stall`=0.
- Store lanes:
  - sw: byteen 1111, data as-is.
  - sh: byteen 0011 when addr[1]=0, else 1100; data {2{wdata[15:0]}}.
  - sb: byteen = 0001<<addr[1:0]; data {4{wdata[7:0]}}.
- BUSY:
  - `m_data_req`=1 and `M_stall`=1.
  - On ack, capture the extended `m_data_rdata` into `M_DMRD` (loads only; stores leave it unchanged), drop req, go to DONE.
- Load extension: select the lane by addr[1:0].
  - lb sign-extends; lbu zero-extends.
  - lh sign-extends; lhu zero-extends.
  - lw passes the word through.
- DONE: `M_stall`=0 and `M_DMRD` is valid. The pipeline advances at this edge. The next state is always IDLE, so there is no reissue.
- `Req` in BUSY: the bus cannot abort. Set a drop flag, keep waiting for ack, then go to DONE without updating `M_DMRD`. Clear the flag in IDLE.
- `Req` in DONE has no effect on this block.

## Timing
- Reset clears the following; FSM goes to IDLE:
  - Registered outputs: `M_DMRD`, `m_data_req`, `m_data_addr`, `m_data_wdata`, `m_data_byteen`.
  - Drop flag.
- Combinational outputs `M_stall` and `M_exc` are 0 while `rst` is held.
- Launch at cycle T (IDLE). `m_data_req`=1 from T+1.
- Ack at T+1+k (k≥0). DONE at T+2+k. Stall cycles = 2+k.
- With k=0, total M residency is 3 cycles.
- `rst` mid-BUSY returns to IDLE immediately. A late ack is ignored because the FSM is in IDLE.
- Ack arriving outside BUSY is ignored.

## Test plan
- lw 0x0000_0010 with rdata 0xDEADBEEF acked at the first BUSY cycle: stall is high for 2 cycles, `M_DMRD`=0xDEADBEEF in DONE, req is high for exactly 1 cycle.
- lb/lbu/lh/lhu at addr 0x13 and 0x12 with rdata 0x80FF7F01:
  - lb@13 → 0xFFFFFF80.
  - lbu@13 → 0x00000080.
  - lh@12 → 0xFFFF80FF.
  - lhu@12 → 0x000080FF.
- sb 0x1ACE_00AB at addr 0x21: byteen=0010, wdata=0xABABABAB, m_data_addr=0x20. Ack delayed 3 cycles gives 5 stall cycles.
- Each exception case gives the listed `M_exc` with zero stall and no req:
  - lw 0x0002 → 4.
  - sh 0x0001 → 5.
  - lb 0x7F00 → 4.
  - sw 0x7F08 → 5.
  - sw 0x3000 → 5.
- Req pulse during BUSY on an lw: stall persists until ack, `M_DMRD` is unchanged, then the FSM returns to IDLE.
- `rst` asserted mid-BUSY: all outputs are 0 asynchronously, and a subsequent stray ack causes no transition.
